decode: RTL and testbench

// - Serial receive-side frame decoder for the FSK link: hunts for a 3-bit header, captures a
//   7-bit Hamming(7,4) codeword, corrects any single-bit error and replays the 4 data bits

---
 rtl/decode.sv | 108 ++++++++++
 tb/tb_decode.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/decode.sv
// Serial Hamming(7,4) frame decoder: hunts for the 110 header, captures a 7-bit codeword,
// corrects any single-bit error and replays the 4 data bits d3 first with an error flag.
module decode (
    input  logic clk,
    input  logic rst_n,      // synchronous, active-high despite the suffix
    input  logic inputData,
    output logic outputData,
    output logic wrg_show
);

    typedef enum logic [1:0] {
        IDLE,
        H1,
        H2,
        DATA
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        frame_done;
    logic [2:0]  cnt;
    logic [5:0]  rx_sr;
    logic [3:0]  out_sr;

    logic [6:0]  codeword;
    logic [3:0]  data_rx;
    logic [2:0]  parity_rx;
    logic [2:0]  parity_calc;
    logic [2:0]  syndrome;
    logic [3:0]  data_fixed;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            IDLE: if (inputData) state_next = H1;
            H1:   state_next = inputData ? H2 : IDLE;
            H2:   if (!inputData) state_next = DATA;   // extra leading 1s stay in H2
            DATA: begin
                if (cnt == 3'd6) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt   <= 3'd0;
            rx_sr <= 6'd0;
        end else if (state == DATA) begin
            rx_sr <= {rx_sr[4:0], inputData};
            cnt   <= frame_done ? 3'd0 : cnt + 3'd1;
        end else begin
            cnt   <= 3'd0;
        end
    end

    // The last bit (c0) is still on the input when the frame completes.
    assign codeword  = {rx_sr, inputData};
    assign data_rx   = codeword[6:3];
    assign parity_rx = codeword[2:0];

    assign parity_calc = {data_rx[3] ^ data_rx[2] ^ data_rx[1],
                          data_rx[3] ^ data_rx[2] ^ data_rx[0],
                          data_rx[3] ^ data_rx[1] ^ data_rx[0]};
    assign syndrome    = parity_rx ^ parity_calc;

    always_comb begin
        data_fixed = data_rx;
        case (syndrome)
            3'b111:  data_fixed[3] = ~data_rx[3];
            3'b110:  data_fixed[2] = ~data_rx[2];
            3'b101:  data_fixed[1] = ~data_rx[1];
            3'b011:  data_fixed[0] = ~data_rx[0];
            default: data_fixed = data_rx;   // clean, or a parity bit was hit
        endcase
    end

    // Replay shifter runs independently of the header hunt; zero fill keeps the line low.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_sr   <= 4'd0;
            wrg_show <= 1'b0;
        end else if (frame_done) begin
            out_sr   <= data_fixed;
            wrg_show <= |syndrome;
        end else begin
            out_sr   <= {out_sr[2:0], 1'b0};
        end
    end

    assign outputData = out_sr[3];

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: frames are driven bit by bit, expected replays are queued
// when a frame is sent and popped when its last bit has been sampled.
module tb_decode;

    typedef struct packed {
        logic [3:0] data;
        logic       wrg;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic inputData;
    logic outputData;
    logic wrg_show;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] rep_data = 4'd0;
    int         rep_left = 0;
    logic       exp_wrg  = 1'b0;

    decode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inputData  (inputData),
        .outputData (outputData),
        .wrg_show   (wrg_show)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one bit, let one rising edge pass, then check both outputs.
    task automatic step(input logic b, input logic rst, input logic completes, input string tag);
        exp_t e;
        inputData = b;
        rst_n     = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            rep_left = 0;
            exp_wrg  = 1'b0;
        end else if (completes) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL %s scoreboard observed=empty expected=entry", tag);
            end
            if (sb.size() > 0) begin
                e        = sb.pop_front();
                rep_data = e.data;
                rep_left = 4;
                exp_wrg  = e.wrg;
            end
        end
        check({tag, "_out"}, outputData, (rep_left > 0) ? rep_data[3] : 1'b0);
        check({tag, "_wrg"}, wrg_show, exp_wrg);
        if (rep_left > 0) begin
            rep_data = {rep_data[2:0], 1'b0};
            rep_left--;
        end
    endtask

    task automatic send_frame(input logic [6:0] cw, input logic [3:0] d, input logic w,
                              input string tag);
        logic [2:0] hdr;
        exp_t e;
        hdr    = 3'b110;
        e.data = d;
        e.wrg  = w;
        sb.push_back(e);
        for (int i = 2; i >= 0; i--) step(hdr[i], 1'b0, 1'b0, tag);
        for (int i = 6; i >= 0; i--) step(cw[i], 1'b0, (i == 0), tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic [9:0] rst_frame;
        rst_frame = 10'b1101000111;
        rst_n     = 1'b1;
        inputData = 1'b0;

        // A valid frame driven while reset is held must leave no trace.
        for (int i = 9; i >= 0; i--) step(rst_frame[i], 1'b1, 1'b0, "in_reset");
        idle(6, "post_reset");

        send_frame(7'b1000111, 4'b1000, 1'b0, "clean");
        idle(3, "gap");

        // Back-to-back frames at the minimum 10-bit spacing, replay overlapping hunt.
        send_frame(7'b1001111, 4'b1000, 1'b1, "syn011");
        send_frame(7'b1010111, 4'b1000, 1'b1, "syn101");
        send_frame(7'b1100111, 4'b1000, 1'b1, "syn110");
        send_frame(7'b0000111, 4'b1000, 1'b1, "syn111");
        send_frame(7'b0010111, 4'b0010, 1'b1, "syn010");
        send_frame(7'b1011111, 4'b1111, 1'b1, "d2fix");
        idle(2, "gap");

        // False header 10, then 1110 where the trailing 110 is the real header.
        step(1'b1, 1'b0, 1'b0, "false10");
        step(1'b0, 1'b0, 1'b0, "false10");
        idle(1, "false_gap");
        step(1'b1, 1'b0, 1'b0, "prefix1");
        send_frame(7'b1111111, 4'b1111, 1'b0, "after_false");
        idle(5, "gap");

        // Flagged frame, then reset in the middle of the next codeword.
        send_frame(7'b1001111, 4'b1000, 1'b1, "pre_abort");
        step(1'b1, 1'b0, 1'b0, "abort_hdr");
        step(1'b1, 1'b0, 1'b0, "abort_hdr");
        step(1'b0, 1'b0, 1'b0, "abort_hdr");
        step(1'b1, 1'b0, 1'b0, "abort_cw");
        step(1'b1, 1'b0, 1'b0, "abort_cw");
        step(1'b0, 1'b0, 1'b0, "abort_cw");
        step(1'b0, 1'b1, 1'b0, "abort_rst");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, "abort_tail");
        idle(6, "final");

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
